// File: rtl/up_adc_pn_monitor.sv
// -----------------------------------------------------------------------------
// up_adc_pn_monitor
//
// Per-channel PN-sequence monitor status block for the JESD204 TPL ADC.
// Collects the per-channel PN checker results into sticky write-1-to-clear
// flags and saturating error counters, and raises a maskable level interrupt
// from the sticky flags. Lives on the up_* register bus next to
// up_adc_common/up_adc_channel; up_rdata is zero whenever no read is being
// acknowledged, so it can be OR-combined with the other slaves' read data.
//
// Register window (word offsets from ADDR_BASE, 64 words):
//   0x00       INFO      RO  {16'h0001, 8'h00, NUM_CHANNELS[7:0]}
//   0x01       OOS_STKY  W1C bit n set on any cycle pn_oos[n]=1
//   0x02       ERR_STKY  W1C bit n set on any cycle pn_err[n]=1
//   0x03       IRQ_MASK  RW  1 = masked, resets to all ones
//   0x04       IRQ_PEND  RO  (OOS_STKY | ERR_STKY) & ~IRQ_MASK
//   0x05       CONTROL   RW  bit0 FREEZE, bit1 CLR_ALL (write-1 pulse, reads 0)
//   0x20+n     ERR_CNT n     read count, any write clears it
//
// Ports:
//   up_clk, up_rstn        clock, asynchronous active-low reset
//   pn_err[NUM_CHANNELS]   per-channel PN mismatch pulse (one per bad word)
//   pn_oos[NUM_CHANNELS]   per-channel PN out-of-sync level
//   up_wreq/waddr/wdata    write request, acknowledged by up_wack
//   up_rreq/raddr          read request, acknowledged by up_rack + up_rdata
//   irq                    registered level interrupt, active high
// -----------------------------------------------------------------------------
module up_adc_pn_monitor #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter logic [13:0] ADDR_BASE    = 14'h0000
) (
  input  logic                    up_clk,
  input  logic                    up_rstn,
  input  logic [NUM_CHANNELS-1:0] pn_err,
  input  logic [NUM_CHANNELS-1:0] pn_oos,
  input  logic                    up_wreq,
  input  logic [13:0]             up_waddr,
  input  logic [31:0]             up_wdata,
  output logic                    up_wack,
  input  logic                    up_rreq,
  input  logic [13:0]             up_raddr,
  output logic [31:0]             up_rdata,
  output logic                    up_rack,
  output logic                    irq
);

  typedef enum logic [5:0] {
    REG_INFO     = 6'h00,
    REG_OOS_STKY = 6'h01,
    REG_ERR_STKY = 6'h02,
    REG_IRQ_MASK = 6'h03,
    REG_IRQ_PEND = 6'h04,
    REG_CONTROL  = 6'h05
  } reg_off_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [7:0]           NUM_CH8 = 8'(NUM_CHANNELS);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       wr_hit;
  logic       rd_hit;
  logic [5:0] woff;
  logic [5:0] roff;

  assign wr_hit = up_wreq && (up_waddr[13:6] == ADDR_BASE[13:6]);
  assign rd_hit = up_rreq && (up_raddr[13:6] == ADDR_BASE[13:6]);
  assign woff   = up_waddr[5:0];
  assign roff   = up_raddr[5:0];

  // Only the low NUM_CHANNELS bits of write data carry meaning for most
  // registers; the rest are folded here so they are visibly consumed.
  logic unused_wdata;
  assign unused_wdata = ^up_wdata;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_CHANNELS-1:0] oos_q,  oos_d;
  logic [NUM_CHANNELS-1:0] err_q,  err_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic                    freeze_q, freeze_d;
  logic [CNT_WIDTH-1:0]    cnt_q [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]    cnt_d [NUM_CHANNELS];
  logic                    irq_q,   irq_d;
  logic                    wack_q,  wack_d;
  logic                    rack_q,  rack_d;
  logic [31:0]             rdata_q, rdata_d;

  logic [NUM_CHANNELS-1:0] pend;
  logic [NUM_CHANNELS-1:0] w1c_oos;
  logic [NUM_CHANNELS-1:0] w1c_err;
  logic                    clr_all;

  assign pend    = (oos_q | err_q) & ~mask_q;
  assign w1c_oos = (wr_hit && (woff == REG_OOS_STKY)) ? up_wdata[NUM_CHANNELS-1:0] : '0;
  assign w1c_err = (wr_hit && (woff == REG_ERR_STKY)) ? up_wdata[NUM_CHANNELS-1:0] : '0;
  assign clr_all = wr_hit && (woff == REG_CONTROL) && up_wdata[1];

  // ---------------------------------------------------------------------------
  // Next-state: registers, stickies, counters
  // ---------------------------------------------------------------------------
  always_comb begin
    // Clear is applied before OR-ing the new events so a set in the same
    // cycle as the W1C keeps the flag.
    oos_d    = (oos_q & ~w1c_oos) | pn_oos;
    err_d    = (err_q & ~w1c_err) | pn_err;
    mask_d   = mask_q;
    freeze_d = freeze_q;
    irq_d    = |pend;
    wack_d   = wr_hit;

    if (wr_hit && (woff == REG_IRQ_MASK)) begin
      mask_d = up_wdata[NUM_CHANNELS-1:0];
    end
    if (wr_hit && (woff == REG_CONTROL)) begin
      freeze_d = up_wdata[0];
    end

    for (int unsigned n = 0; n < NUM_CHANNELS; n++) begin
      cnt_d[n] = cnt_q[n];
      // Clear has priority over a coincident increment.
      if (clr_all || (wr_hit && (woff == 6'(32 + n)))) begin
        cnt_d[n] = '0;
      end else if (pn_err[n] && !pn_oos[n] && !freeze_q && (cnt_q[n] != CNT_MAX)) begin
        cnt_d[n] = cnt_q[n] + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: data is captured with the request and held for the single ack
  // cycle; any other cycle returns zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_d = '0;
    rack_d  = rd_hit;
    if (rd_hit) begin
      case (roff)
        REG_INFO:     rdata_d = {16'h0001, 8'h00, NUM_CH8};
        REG_OOS_STKY: rdata_d[NUM_CHANNELS-1:0] = oos_q;
        REG_ERR_STKY: rdata_d[NUM_CHANNELS-1:0] = err_q;
        REG_IRQ_MASK: rdata_d[NUM_CHANNELS-1:0] = mask_q;
        REG_IRQ_PEND: rdata_d[NUM_CHANNELS-1:0] = pend;
        REG_CONTROL:  rdata_d[0] = freeze_q;
        default: begin
          for (int unsigned n = 0; n < NUM_CHANNELS; n++) begin
            if (roff == 6'(32 + n)) begin
              rdata_d[CNT_WIDTH-1:0] = cnt_q[n];
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      oos_q    <= '0;
      err_q    <= '0;
      mask_q   <= '1;
      freeze_q <= 1'b0;
      irq_q    <= 1'b0;
      wack_q   <= 1'b0;
      rack_q   <= 1'b0;
      rdata_q  <= '0;
      for (int unsigned n = 0; n < NUM_CHANNELS; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      oos_q    <= oos_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
      freeze_q <= freeze_d;
      irq_q    <= irq_d;
      wack_q   <= wack_d;
      rack_q   <= rack_d;
      rdata_q  <= rdata_d;
      for (int unsigned n = 0; n < NUM_CHANNELS; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign up_wack  = wack_q;
  assign up_rack  = rack_q;
  assign up_rdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_up_adc_pn_monitor.sv
// -----------------------------------------------------------------------------
// Scoreboard testbench for up_adc_pn_monitor (4 channels, 4-bit counters,
// non-zero base address). The driver applies one bus/PN cycle at a time,
// queues the expected read data and ack cycles, and advances an abstract
// model of the register file. A monitor on the falling edge pops and compares
// whenever an ack appears, and also checks idle read data and irq.
// -----------------------------------------------------------------------------
module tb_up_adc_pn_monitor;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;
  localparam logic [13:0] BASE = 14'h0140;

  logic            up_clk;
  logic            up_rstn;
  logic [NCH-1:0]  pn_err;
  logic [NCH-1:0]  pn_oos;
  logic            up_wreq;
  logic [13:0]     up_waddr;
  logic [31:0]     up_wdata;
  logic            up_wack;
  logic            up_rreq;
  logic [13:0]     up_raddr;
  logic [31:0]     up_rdata;
  logic            up_rack;
  logic            irq;

  up_adc_pn_monitor #(
    .NUM_CHANNELS (NCH),
    .CNT_WIDTH    (CW),
    .ADDR_BASE    (BASE)
  ) dut (
    .up_clk   (up_clk),
    .up_rstn  (up_rstn),
    .pn_err   (pn_err),
    .pn_oos   (pn_oos),
    .up_wreq  (up_wreq),
    .up_waddr (up_waddr),
    .up_wdata (up_wdata),
    .up_wack  (up_wack),
    .up_rreq  (up_rreq),
    .up_raddr (up_raddr),
    .up_rdata (up_rdata),
    .up_rack  (up_rack),
    .irq      (irq)
  );

  initial begin
    up_clk = 1'b0;
    forever #5 up_clk = ~up_clk;
  end

  int unsigned cyc = 0;
  always @(posedge up_clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } rexp_t;

  rexp_t       rq[$];
  int unsigned wq[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned    cnt_m [NCH];
  logic [NCH-1:0] oos_m, err_m, mask_m;
  logic           freeze_m;
  logic           irq_m;

  task automatic model_reset();
    for (int i = 0; i < int'(NCH); i++) cnt_m[i] = 0;
    oos_m    = '0;
    err_m    = '0;
    mask_m   = '1;
    freeze_m = 1'b0;
    irq_m    = 1'b0;
  endtask

  function automatic logic hit(input logic [13:0] a);
    return a[13:6] == BASE[13:6];
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] off);
    logic [31:0] v;
    int          o;
    v = '0;
    o = int'(off);
    case (o)
      0: v = {16'h0001, 8'h00, 8'(NCH)};
      1: v[NCH-1:0] = oos_m;
      2: v[NCH-1:0] = err_m;
      3: v[NCH-1:0] = mask_m;
      4: v[NCH-1:0] = (oos_m | err_m) & ~mask_m;
      5: v[0] = freeze_m;
      default: if (o >= 32 && o < 32 + int'(NCH)) v = 32'(cnt_m[o - 32]);
    endcase
    return v;
  endfunction

  task automatic model_update(input logic [NCH-1:0] e, input logic [NCH-1:0] o,
                              input logic whit, input logic [5:0] off, input logic [31:0] wd);
    logic irq_next;
    logic clr_all;
    irq_next = |((oos_m | err_m) & ~mask_m);
    clr_all  = whit && (off == 6'h05) && wd[1];
    for (int n = 0; n < int'(NCH); n++) begin
      if (clr_all || (whit && int'(off) == 32 + n)) cnt_m[n] = 0;
      else if (e[n] && !o[n] && !freeze_m && cnt_m[n] < CMAX) cnt_m[n] = cnt_m[n] + 1;
    end
    if (whit && off == 6'h01) oos_m = oos_m & ~wd[NCH-1:0];
    if (whit && off == 6'h02) err_m = err_m & ~wd[NCH-1:0];
    oos_m = oos_m | o;
    err_m = err_m | e;
    if (whit && off == 6'h03) mask_m = wd[NCH-1:0];
    if (whit && off == 6'h05) freeze_m = wd[0];
    irq_m = irq_next;
  endtask

  // ---------------- driver ----------------
  task automatic drive_idle();
    pn_err   = '0;
    pn_oos   = '0;
    up_wreq  = 1'b0;
    up_waddr = '0;
    up_wdata = '0;
    up_rreq  = 1'b0;
    up_raddr = '0;
  endtask

  // One clock of stimulus; entered shortly after a rising edge.
  task automatic step(input logic [NCH-1:0] e, input logic [NCH-1:0] o,
                      input logic wr, input logic [13:0] wa, input logic [31:0] wd,
                      input logic rd, input logic [13:0] ra);
    pn_err   = e;
    pn_oos   = o;
    up_wreq  = wr;
    up_waddr = wa;
    up_wdata = wd;
    up_rreq  = rd;
    up_raddr = ra;
    if (rd && hit(ra)) rq.push_back('{data: model_read(ra[5:0]), due: cyc + 1});
    if (wr && hit(wa)) wq.push_back(cyc + 1);
    @(posedge up_clk);
    model_update(e, o, wr && hit(wa), wa[5:0], wd);
    #1;
    drive_idle();
  endtask

  function automatic logic [13:0] A(input logic [5:0] off);
    return {BASE[13:6], off};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask
  task automatic wr(input logic [5:0] off, input logic [31:0] d);
    step('0, '0, 1'b1, A(off), d, 1'b0, '0);
  endtask
  task automatic rd(input logic [5:0] off);
    step('0, '0, 1'b0, '0, '0, 1'b1, A(off));
  endtask
  task automatic pn(input logic [NCH-1:0] e, input logic [NCH-1:0] o, input int n);
    for (int i = 0; i < n; i++) step(e, o, 1'b0, '0, '0, 1'b0, '0);
  endtask
  task automatic rd_all();
    for (int i = 0; i < 6; i++) rd(6'(i));
    for (int i = 0; i < int'(NCH); i++) rd(6'(32 + i));
  endtask

  // ---------------- monitor ----------------
  initial begin
    rexp_t       r;
    int unsigned d;
    forever begin
      @(negedge up_clk);
      if (up_rack) begin
        if (rq.size() == 0) chk("unexpected_rack", 32'(up_rack), 32'd0);
        else begin
          r = rq.pop_front();
          chk("rack_cycle", cyc, r.due);
          chk("rdata", up_rdata, r.data);
        end
      end else begin
        chk("rdata_idle", up_rdata, 32'd0);
        if (rq.size() > 0 && rq[0].due <= cyc) begin
          r = rq.pop_front();
          chk("missing_rack", 32'(up_rack), 32'd1);
        end
      end
      if (up_wack) begin
        if (wq.size() == 0) chk("unexpected_wack", 32'(up_wack), 32'd0);
        else begin
          d = wq.pop_front();
          chk("wack_cycle", cyc, d);
        end
      end else if (wq.size() > 0 && wq[0] <= cyc) begin
        d = wq.pop_front();
        chk("missing_wack", 32'(up_wack), 32'd1);
      end
      chk("irq", 32'(irq), 32'(irq_m));
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0] offs [11];

  initial begin
    drive_idle();
    model_reset();
    offs = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h10, 6'h20, 6'h21, 6'h22, 6'h23};
    up_rstn = 1'b1;
    #1 up_rstn = 1'b0;
    repeat (3) @(posedge up_clk);
    #1 up_rstn = 1'b1;

    // Reset values and handshake timing.
    rd(6'h00);
    rd(6'h03);
    idle(2);
    rd_all();

    // Error counting with and without out-of-sync.
    pn(4'b0100, 4'b0000, 5);
    rd(6'h22);
    rd(6'h02);
    wr(6'h22, 32'h0);
    wr(6'h02, 32'hFFFF_FFFF);
    pn(4'b0100, 4'b0100, 5);
    rd(6'h22);
    rd(6'h01);
    rd(6'h02);

    // Saturation and clear-vs-increment priority.
    pn(4'b0001, 4'b0000, 20);
    rd(6'h20);
    wr(6'h20, 32'h1234);
    rd(6'h20);
    pn(4'b0001, 4'b0000, 3);
    step(4'b0001, 4'b0000, 1'b1, A(6'h20), 32'h0, 1'b0, '0);
    rd(6'h20);

    // Interrupt path.
    wr(6'h01, 32'hF);
    wr(6'h02, 32'hF);
    wr(6'h03, 32'hE);
    idle(2);
    pn(4'b0000, 4'b0001, 1);
    idle(3);
    rd(6'h04);
    wr(6'h01, 32'h1);
    idle(3);
    pn(4'b0000, 4'b0001, 1);
    step(4'b0000, 4'b0001, 1'b1, A(6'h01), 32'h1, 1'b0, '0);
    rd(6'h01);
    wr(6'h01, 32'h1);
    idle(2);

    // Freeze, clear-all, unmapped offsets, unused bits, misses.
    wr(6'h05, 32'h1);
    pn(4'b0010, 4'b0000, 3);
    rd(6'h21);
    rd(6'h05);
    wr(6'h05, 32'h0);
    pn(4'b1111, 4'b0000, 2);
    wr(6'h05, 32'h2);
    rd_all();
    wr(6'h10, 32'hFFFF_FFFF);
    rd(6'h10);
    wr(6'h03, 32'hFFFF_FFF0);
    rd(6'h03);
    step('0, '0, 1'b1, {BASE[13:6] + 8'd1, 6'h03}, 32'hF, 1'b1, {BASE[13:6] - 8'd1, 6'h00});
    step('0, '0, 1'b1, 14'h0000, 32'hF, 1'b1, 14'h0003);
    rd(6'h03);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      logic [NCH-1:0] e, o;
      logic           w, r;
      logic [13:0]    wa, ra;
      e  = NCH'($urandom_range(0, 15) & $urandom_range(0, 15));
      o  = ($urandom_range(0, 7) == 0) ? NCH'($urandom_range(0, 15)) : '0;
      w  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 1) == 0);
      wa = A(offs[$urandom_range(0, 10)]);
      ra = A(offs[$urandom_range(0, 10)]);
      if ($urandom_range(0, 9) == 0) wa[13:6] = wa[13:6] + 8'd3;
      if ($urandom_range(0, 9) == 0) ra[13:6] = ra[13:6] ^ 8'h10;
      step(e, o, w, wa, $urandom, r, ra);
    end
    idle(3);
    rd_all();

    // Asynchronous reset while a read is awaiting its ack.
    idle(3);
    up_rreq  = 1'b1;
    up_raddr = A(6'h00);
    #3;
    up_rstn = 1'b0;
    model_reset();
    rq.delete();
    wq.delete();
    @(posedge up_clk);
    #1 drive_idle();
    repeat (2) @(posedge up_clk);
    #1 up_rstn = 1'b1;
    idle(2);
    rd_all();
    idle(3);

    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
